// File: rtl/pmod_sd_pkg.sv
// Shared types and constants for the Pmod SD connector bridge.
package pmod_sd_pkg;

  typedef enum logic [1:0] {
    HOLDOFF = 2'd0,
    RUN     = 2'd1,
    NOCARD  = 2'd2
  } state_t;

  localparam logic [1:0] TOP_SS   = 2'd0;
  localparam logic [1:0] TOP_MOSI = 2'd1;
  localparam logic [1:0] TOP_MISO = 2'd2;
  localparam logic [1:0] TOP_SCK  = 2'd3;

  localparam logic [1:0] BOT_DAT1 = 2'd0;
  localparam logic [1:0] BOT_DAT2 = 2'd1;
  localparam logic [1:0] BOT_CD   = 2'd2;
  localparam logic [1:0] BOT_WP   = 2'd3;

  // Values presented on the top row and to the SPI master while isolated
  localparam logic [3:0] ISO_TOP_O = 4'h0;
  localparam logic [3:0] ISO_TOP_T = 4'hF;
  localparam logic       ISO_SS_I  = 1'b1;
  localparam logic       ISO_IO1_I = 1'b1;
  localparam logic       ISO_IO0_I = 1'b0;
  localparam logic       ISO_SCK_I = 1'b0;

endpackage

// File: rtl/pmod_sd_bridge_debounce.sv
// Two-flop synchroniser plus stability counter for one slow connector pin.
module pmod_debounce #(
  parameter int unsigned CYCLES    = 65536,
  parameter bit          RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin,
  output logic stable
);

  localparam int unsigned CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A new level is accepted only after CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync   <= {2{RESET_VAL}};
      cnt    <= '0;
      stable <= RESET_VAL;
    end else begin
      sync <= {sync[0], pin};
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync[1];
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pmod_sd_bridge.sv
// Pmod SD bridge: SPI on the top row, DAT1/DAT2 GPIO on the bottom row, debounced
// card-detect / write-protect, power-up hold-off and card-change interrupt.
module pmod_sd_bridge
  import pmod_sd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 65536,
  parameter int unsigned POWERUP_CYCLES  = 1000000,
  parameter int unsigned CD_ACTIVE_LOW   = 1,
  parameter int unsigned WP_ACTIVE_LOW   = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       m_ss_o,
  input  logic       m_ss_t,
  output logic       m_ss_i,
  input  logic       m_sck_o,
  input  logic       m_sck_t,
  output logic       m_sck_i,
  input  logic       m_io0_o,
  input  logic       m_io0_t,
  output logic       m_io0_i,
  input  logic       m_io1_o,
  input  logic       m_io1_t,
  output logic       m_io1_i,
  input  logic [1:0] gpio_in_o,
  input  logic [1:0] gpio_in_t,
  output logic [1:0] gpio_in_i,
  output logic [3:0] pmod_top_o,
  output logic [3:0] pmod_top_t,
  input  logic [3:0] pmod_top_i,
  output logic [3:0] pmod_bot_o,
  output logic [3:0] pmod_bot_t,
  input  logic [3:0] pmod_bot_i,
  output logic       card_present,
  output logic       write_protect,
  output logic       card_ready,
  output logic       irq,
  input  logic       irq_clr
);

  localparam int unsigned HW = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
  localparam int unsigned HOLD_LAST = (POWERUP_CYCLES == 0) ? 0 : POWERUP_CYCLES - 1;
  localparam bit CD_LOW = (CD_ACTIVE_LOW != 0);
  localparam bit WP_LOW = (WP_ACTIVE_LOW != 0);

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic          present_q;
  logic          cd_stable;
  logic          wp_stable;
  logic          run;

  pmod_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(CD_LOW)) u_cd_debounce (
    .clk    (clk),
    .resetn (resetn),
    .pin    (pmod_bot_i[BOT_CD]),
    .stable (cd_stable)
  );

  pmod_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RESET_VAL(WP_LOW)) u_wp_debounce (
    .clk    (clk),
    .resetn (resetn),
    .pin    (pmod_bot_i[BOT_WP]),
    .stable (wp_stable)
  );

  assign card_present  = CD_LOW ? ~cd_stable : cd_stable;
  assign write_protect = WP_LOW ? ~wp_stable : wp_stable;
  assign run           = (state == RUN);
  assign card_ready    = run;

  // Card state machine; every insertion restarts the power-up hold-off
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= HOLDOFF;
      hold_cnt  <= '0;
      present_q <= 1'b0;
      irq       <= 1'b0;
    end else begin
      present_q <= card_present;
      if (card_present != present_q) begin
        irq <= 1'b1;
      end else if (irq_clr) begin
        irq <= 1'b0;
      end
      unique case (state)
        HOLDOFF: begin
          if (present_q && !card_present) begin
            state    <= NOCARD;
            hold_cnt <= '0;
          end else if (card_present && !present_q && POWERUP_CYCLES != 0) begin
            hold_cnt <= '0;
          end else if (POWERUP_CYCLES == 0 || hold_cnt == HW'(HOLD_LAST)) begin
            state    <= card_present ? RUN : NOCARD;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          if (!card_present) state <= NOCARD;
        end
        NOCARD: begin
          if (card_present) begin
            state    <= HOLDOFF;
            hold_cnt <= '0;
          end
        end
        default: state <= HOLDOFF;
      endcase
    end
  end

  // Top row follows the SPI master only while a ready card is present
  always_comb begin
    pmod_top_o = ISO_TOP_O;
    pmod_top_t = ISO_TOP_T;
    m_ss_i     = ISO_SS_I;
    m_io0_i    = ISO_IO0_I;
    m_io1_i    = ISO_IO1_I;
    m_sck_i    = ISO_SCK_I;
    if (run) begin
      pmod_top_o[TOP_SS]   = m_ss_o;
      pmod_top_o[TOP_MOSI] = m_io0_o;
      pmod_top_o[TOP_MISO] = m_io1_o;
      pmod_top_o[TOP_SCK]  = m_sck_o;
      pmod_top_t[TOP_SS]   = m_ss_t;
      pmod_top_t[TOP_MOSI] = m_io0_t;
      pmod_top_t[TOP_MISO] = m_io1_t;
      pmod_top_t[TOP_SCK]  = m_sck_t;
      m_ss_i  = pmod_top_i[TOP_SS];
      m_io0_i = pmod_top_i[TOP_MOSI];
      m_io1_i = pmod_top_i[TOP_MISO];
      m_sck_i = pmod_top_i[TOP_SCK];
    end
  end

  // Bottom row: DAT1/DAT2 pass straight through, CD/WP are input-only
  always_comb begin
    pmod_bot_o = 4'h0;
    pmod_bot_t = 4'hF;
    pmod_bot_o[BOT_DAT1] = gpio_in_o[0];
    pmod_bot_o[BOT_DAT2] = gpio_in_o[1];
    pmod_bot_t[BOT_DAT1] = gpio_in_t[0];
    pmod_bot_t[BOT_DAT2] = gpio_in_t[1];
    gpio_in_i = {pmod_bot_i[BOT_DAT2], pmod_bot_i[BOT_DAT1]};
  end

endmodule

// File: doc/pmod_sd_bridge.md
Name: pmod_sd_bridge

Overview:
Parametrised Pmod SD connector bridge. Maps an AXI Quad SPI master onto the Pmod top row and two GPIO channels (DAT1/DAT2) onto the Pmod bottom row. Debounces the card-detect (CD) and write-protect (WP) pins and enforces a power-up hold-off after each card insertion. Isolates the SPI pins while no card is ready and raises an interrupt on every card-state change. Sits between the SPI/GPIO IP and the Pmod Bridge in the PmodSD hierarchy.

Parameters:
DEBOUNCE_CYCLES, 65536, consecutive stable samples required to accept a new CD/WP level; must be >= 1
POWERUP_CYCLES, 1000000, hold-off cycles after reset or card insertion before SPI pins are driven; 0 = no hold-off
CD_ACTIVE_LOW, 1, 1: CD pin low means card present
WP_ACTIVE_LOW, 0, 1: WP pin low means write-protected

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
m_ss_o / m_ss_t / m_ss_i  in/in/out  1  SPI slave select
m_sck_o / m_sck_t / m_sck_i  in/in/out  1  SPI clock
m_io0_o / m_io0_t / m_io0_i  in/in/out  1  MOSI
m_io1_o / m_io1_t / m_io1_i  in/in/out  1  MISO
gpio_in_o / gpio_in_t / gpio_in_i  in/in/out  2  DAT1 (bit0), DAT2 (bit1)
pmod_top_o / pmod_top_t  out/out  4  top row: bit0 SS, bit1 MOSI, bit2 MISO, bit3 SCK
pmod_top_i  in  4  top row inputs
pmod_bot_o / pmod_bot_t  out/out  4  bottom row: bit0 DAT1, bit1 DAT2, bit2 CD, bit3 WP
pmod_bot_i  in  4  bottom row inputs
card_present  out  1  debounced CD, active-high
write_protect  out  1  debounced WP, active-high
card_ready  out  1  high in RUN state
irq  out  1  sticky card-change interrupt
irq_clr  in  1  single-cycle clear of irq

Behaviour:
- Reset values:
  - state = HOLDOFF, hold-off counter = 0.
  - card_present = 0, write_protect = 0, card_ready = 0, irq = 0.
  - Debouncer stable values = deasserted (card absent, not protected).
  - pmod_top_t = 4'hF, pmod_top_o = 0.
- Bottom row:
  - pmod_bot_t[3:2] = 1 and pmod_bot_o[3:2] = 0 at all times.
  - Bits [1:0] are a combinational pass-through of gpio_in_o/t; gpio_in_i = pmod_bot_i[1:0].
- Debounce, per CD and WP pin:
  - 2-flop synchroniser, then a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Counter clears whenever the synchronised sample equals the stable value.
  - Stable value updates when the counter reaches DEBOUNCE_CYCLES-1 with the sample still differing.
  - Polarity is applied after debouncing.
  - Latency from a clean pin edge to card_present change = DEBOUNCE_CYCLES+2 cycles.
- State machine (registered):
  - HOLDOFF: top row isolated. Leave when the counter reaches POWERUP_CYCLES-1 (immediately if 0): to RUN if card_present, else NOCARD. If card_present falls during HOLDOFF, go to NOCARD at once and clear the counter.
  - RUN: top row combinational pass-through (pmod_top_o/t = {sck, io1, io0, ss}); m_*_i = pmod_top_i bits; card_ready = 1. card_present falling -> NOCARD on the next cycle.
  - NOCARD: top row isolated. card_present rising -> HOLDOFF with the counter cleared.
- Isolated means:
  - pmod_top_t = 4'hF, pmod_top_o = 0.
  - m_ss_i = 1, m_io1_i = 1, m_io0_i = 0, m_sck_i = 0, regardless of the pins.
- irq:
  - Set in the cycle after any change of debounced card_present.
  - Cleared by irq_clr. If set and clear occur in the same cycle, set wins.
  - WP changes update write_protect only; they do not set irq.
- resetn low mid-transfer: the top row tristates in the next cycle and hold-off restarts; no glitch on pmod_top_o beyond the forced 0.

Decomposition:
- pmod_sd_pkg holds:
  - state enum {HOLDOFF, RUN, NOCARD}.
  - Pin index constants: TOP_SS=0, TOP_MOSI=1, TOP_MISO=2, TOP_SCK=3, BOT_DAT1=0, BOT_DAT2=1, BOT_CD=2, BOT_WP=3.
  - Isolated-value constants.
- Sub-module pmod_debounce (parameter CYCLES, RESET_VAL): synchroniser plus counter, instantiated twice.

Test Plan:
- DEBOUNCE_CYCLES=4, POWERUP_CYCLES=10; CD held low from reset -> card_present=1 at cycle 6; card_ready=1 after 10 further cycles; irq=1 one cycle after card_present rises.
- CD glitch: 3-cycle low pulse with DEBOUNCE_CYCLES=4 -> card_present stays 0, irq stays 0.
- In RUN, drive m_sck_o=1, m_io0_o=1, m_ss_o=0, all _t=0, pmod_top_i=4'b0100 -> pmod_top_o=4'b1010, pmod_top_t=0, m_io1_i=1 in the same cycle.
- Release CD (high) in RUN -> after debounce, pmod_top_t=4'hF and m_ss_i=1; irq set. Reinsert -> HOLDOFF for 10 cycles, then RUN.
- irq_clr asserted in the same cycle as a new CD change -> irq remains 1; a later irq_clr alone -> irq=0.
- resetn low for 1 cycle in RUN -> pmod_top_t=4'hF, card_present=0, card_ready=0, irq=0 next cycle; then the re-debounce and hold-off sequence repeats.
